// File: rtl/cv_ctrl_ports.sv
// ColecoVision/SG-1000 controller ports: input debounce, keypad/joystick pin encode and
// Super Action spinner quadrature. Define CTRL_AUTOFIRE_EN to build per-button autofire.
module cv_ctrl_ports #(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SPIN_DIV        = 1024,
    parameter int unsigned AUTOFIRE_DIV    = 65536
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    ce_i,
    input  logic [32*NUM_PORTS-1:0] joy_i,
    input  logic [8*NUM_PORTS-1:0]  spin_i,
    input  logic [NUM_PORTS-1:0]    spin_stb_i,
    input  logic [2*NUM_PORTS-1:0]  autofire_i,
    input  logic [NUM_PORTS-1:0]    ctrl_p5_i,
    input  logic [NUM_PORTS-1:0]    ctrl_p8_i,
    output logic [NUM_PORTS-1:0]    ctrl_p1_o,
    output logic [NUM_PORTS-1:0]    ctrl_p2_o,
    output logic [NUM_PORTS-1:0]    ctrl_p3_o,
    output logic [NUM_PORTS-1:0]    ctrl_p4_o,
    output logic [NUM_PORTS-1:0]    ctrl_p6_o,
    output logic [NUM_PORTS-1:0]    ctrl_p7_o,
    output logic [NUM_PORTS-1:0]    ctrl_p9_o
);

    localparam logic [9:0] SPIN_MAX = 10'(SPIN_DIV - 1);

`ifndef CTRL_AUTOFIRE_EN
    logic unused_af;
    assign unused_af = ^{autofire_i, 32'(AUTOFIRE_DIV)};
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [19:0] raw;
        logic [19:0] stable_q;
        logic [1:0]  fire;
        logic [3:0]  kp;
        logic [4:0]  key_pins, joy_pins, pins;
        logic        unused_hi;

        assign raw       = joy_i[32*p +: 20];
        assign unused_hi = ^joy_i[32*p+20 +: 12];

        if (DEBOUNCE_CYCLES == 0) begin : g_nodb
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    stable_q <= '0;
                end else if (ce_i) begin
                    stable_q <= raw;
                end
            end
        end else begin : g_db
            localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
            logic [19:0]   cand_q;
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    cand_q   <= '0;
                    cnt_q    <= '0;
                    stable_q <= '0;
                end else if (ce_i) begin
                    if (raw != cand_q) begin
                        cand_q <= raw;
                        cnt_q  <= '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        stable_q <= cand_q;
                    end
                end
            end
        end

`ifdef CTRL_AUTOFIRE_EN
        localparam int unsigned AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
        localparam logic [AW-1:0] AF_MAX = AW'(AUTOFIRE_DIV - 1);
        logic [1:0]    phase_q;
        logic [AW-1:0] af_cnt_q [2];

        // Phase restarts high whenever the button is released or autofire is off.
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                phase_q     <= '0;
                af_cnt_q[0] <= '0;
                af_cnt_q[1] <= '0;
            end else if (ce_i) begin
                for (int b = 0; b < 2; b++) begin
                    if (!(autofire_i[2*p+b] && stable_q[4+b])) begin
                        phase_q[b]  <= 1'b1;
                        af_cnt_q[b] <= '0;
                    end else if (af_cnt_q[b] == AF_MAX) begin
                        phase_q[b]  <= ~phase_q[b];
                        af_cnt_q[b] <= '0;
                    end else begin
                        af_cnt_q[b] <= af_cnt_q[b] + AW'(1);
                    end
                end
            end
        end

        assign fire = stable_q[5:4] & phase_q;
`else
        assign fire = stable_q[5:4];
`endif

        always_comb begin
            kp = 4'b1111;
            if      (stable_q[8])  kp = 4'b0011;
            else if (stable_q[9])  kp = 4'b1110;
            else if (stable_q[10]) kp = 4'b1101;
            else if (stable_q[11]) kp = 4'b0110;
            else if (stable_q[12]) kp = 4'b0001;
            else if (stable_q[13]) kp = 4'b1001;
            else if (stable_q[14]) kp = 4'b0111;
            else if (stable_q[15]) kp = 4'b1100;
            else if (stable_q[16]) kp = 4'b1000;
            else if (stable_q[17]) kp = 4'b1011;
            else if (stable_q[6])  kp = 4'b1010;
            else if (stable_q[7])  kp = 4'b0101;
            else if (stable_q[18]) kp = 4'b0100;
            else if (stable_q[19]) kp = 4'b0010;
        end

        // Purely combinational: the CPU flips p5/p8 and reads back within a few cycles.
        always_comb begin
            key_pins = ctrl_p5_i[p] ? 5'b11111 : {kp, ~fire[1]};
            joy_pins = ctrl_p8_i[p] ? 5'b11111
                                    : {~stable_q[3], ~stable_q[2], ~stable_q[1], ~stable_q[0],
                                       ~fire[0]};
            pins     = key_pins & joy_pins;
        end

        assign ctrl_p1_o[p] = pins[4];
        assign ctrl_p2_o[p] = pins[3];
        assign ctrl_p3_o[p] = pins[2];
        assign ctrl_p4_o[p] = pins[1];
        assign ctrl_p6_o[p] = pins[0];

        logic [7:0] acc_q, acc_d;
        logic [9:0] tmr_q;
        logic [1:0] quad_q, quad_d;
        logic [9:0] acc_x, spin_x, dec_x, sum_x;
        logic       step;

        assign step = ce_i && (acc_q != 8'd0) && (tmr_q == SPIN_MAX);

        // 10-bit sign-extended sum covers the full -257..255 range before saturation.
        always_comb begin
            acc_x = {{2{acc_q[7]}}, acc_q};
            spin_x = spin_stb_i[p] ? {{2{spin_i[8*p+7]}}, spin_i[8*p +: 8]} : 10'd0;
            dec_x = !step ? 10'd0 : (acc_q[7] ? 10'h3FF : 10'd1);
            sum_x = acc_x + spin_x - dec_x;
            if ($signed(sum_x) > 10'sd127) begin
                acc_d = 8'h7F;
            end else if ($signed(sum_x) < -10'sd128) begin
                acc_d = 8'h80;
            end else begin
                acc_d = sum_x[7:0];
            end
        end

        always_comb begin
            quad_d = quad_q;
            if (step) begin
                if (!acc_q[7]) begin
                    case (quad_q)
                        2'b11:   quad_d = 2'b10;
                        2'b10:   quad_d = 2'b00;
                        2'b00:   quad_d = 2'b01;
                        default: quad_d = 2'b11;
                    endcase
                end else begin
                    case (quad_q)
                        2'b11:   quad_d = 2'b01;
                        2'b01:   quad_d = 2'b00;
                        2'b00:   quad_d = 2'b10;
                        default: quad_d = 2'b11;
                    endcase
                end
            end
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                acc_q  <= '0;
                tmr_q  <= '0;
                quad_q <= 2'b11;
            end else begin
                acc_q  <= acc_d;
                quad_q <= quad_d;
                if (acc_q == 8'd0) begin
                    tmr_q <= '0;
                end else if (ce_i) begin
                    tmr_q <= step ? 10'd0 : tmr_q + 10'd1;
                end
            end
        end

        assign ctrl_p7_o[p] = quad_q[1];
        assign ctrl_p9_o[p] = quad_q[0];
    end

endmodule

// File: tb/tb_cv_ctrl_ports.sv
// Bench for cv_ctrl_ports: directed scenarios plus random traffic against a behavioural model.
module tb_cv_ctrl_ports;
    localparam int NP = 2;
    localparam int DB = 4;
    localparam int SD = 4;
    localparam int AD = 8;

    localparam int         KBIT  [14] = '{8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 6, 7, 18, 19};
    localparam logic [3:0] KCODE [14] = '{4'b0011, 4'b1110, 4'b1101, 4'b0110, 4'b0001,
                                          4'b1001, 4'b0111, 4'b1100, 4'b1000, 4'b1011,
                                          4'b1010, 4'b0101, 4'b0100, 4'b0010};
    localparam logic [1:0] QUAD  [4]  = '{2'b11, 2'b10, 2'b00, 2'b01};

    logic clk_sys = 1'b0;
    logic reset, ce_i;
    logic [32*NP-1:0] joy_i;
    logic [8*NP-1:0]  spin_i;
    logic [NP-1:0]    spin_stb_i;
    logic [2*NP-1:0]  autofire_i;
    logic [NP-1:0]    ctrl_p5_i, ctrl_p8_i;
    logic [NP-1:0]    ctrl_p1_o, ctrl_p2_o, ctrl_p3_o, ctrl_p4_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o;

    int n_pass = 0;
    int n_total = 0;

    // Model state: candidate value and how many ce ticks it has been held, accepted value,
    // spinner count/phase position, and ticks a fire button has been held under autofire.
    logic [19:0] m_cand [NP];
    logic [19:0] m_stab [NP];
    int          m_age  [NP];
    int          m_acc  [NP];
    int          m_tmr  [NP];
    int          m_pos  [NP];
    int          m_held [NP][2];

    int         quad_moves = 0;
    int         p6_moves = 0;
    logic [1:0] last_q = 2'b11;
    logic       last_p6 = 1'b1;

    always #5 clk_sys = ~clk_sys;

    cv_ctrl_ports #(
        .NUM_PORTS      (NP),
        .DEBOUNCE_CYCLES(DB),
        .SPIN_DIV       (SD),
        .AUTOFIRE_DIV   (AD)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce_i      (ce_i),
        .joy_i     (joy_i),
        .spin_i    (spin_i),
        .spin_stb_i(spin_stb_i),
        .autofire_i(autofire_i),
        .ctrl_p5_i (ctrl_p5_i),
        .ctrl_p8_i (ctrl_p8_i),
        .ctrl_p1_o (ctrl_p1_o),
        .ctrl_p2_o (ctrl_p2_o),
        .ctrl_p3_o (ctrl_p3_o),
        .ctrl_p4_o (ctrl_p4_o),
        .ctrl_p6_o (ctrl_p6_o),
        .ctrl_p7_o (ctrl_p7_o),
        .ctrl_p9_o (ctrl_p9_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] dut_pins(input int p);
        return {ctrl_p1_o[p], ctrl_p2_o[p], ctrl_p3_o[p], ctrl_p4_o[p], ctrl_p6_o[p],
                ctrl_p7_o[p], ctrl_p9_o[p]};
    endfunction

    function automatic logic [6:0] model_pins(input int p);
        logic [19:0] s;
        logic [3:0]  key;
        logic [1:0]  fire;
        logic [4:0]  kc, jc;
        s = m_stab[p];
        key = 4'b1111;
        for (int i = 13; i >= 0; i--) if (s[KBIT[i]]) key = KCODE[i];
`ifdef CTRL_AUTOFIRE_EN
        for (int b = 0; b < 2; b++) fire[b] = s[4+b] && ((m_held[p][b] / AD) % 2 == 0);
`else
        fire = s[5:4];
`endif
        kc = ctrl_p5_i[p] ? 5'b11111 : {key, ~fire[1]};
        jc = ctrl_p8_i[p] ? 5'b11111 : {~s[3], ~s[2], ~s[1], ~s[0], ~fire[0]};
        return {kc & jc, QUAD[m_pos[p]]};
    endfunction

    task automatic model_clock();
        for (int p = 0; p < NP; p++) begin
            int   dir, nxt;
            logic stepped;
            if (reset) begin
                m_cand[p] = '0;
                m_stab[p] = '0;
                m_age[p] = 1;
                m_acc[p] = 0;
                m_tmr[p] = 0;
                m_pos[p] = 0;
                m_held[p][0] = 0;
                m_held[p][1] = 0;
            end else begin
                dir = (m_acc[p] > 0) ? 1 : -1;
                stepped = ce_i && (m_acc[p] != 0) && (m_tmr[p] == SD - 1);
                if (m_acc[p] == 0) m_tmr[p] = 0;
                else if (ce_i) m_tmr[p] = stepped ? 0 : m_tmr[p] + 1;
                nxt = m_acc[p] - (stepped ? dir : 0);
                if (stepped) m_pos[p] = (m_pos[p] + dir + 4) % 4;
                if (spin_stb_i[p]) nxt += int'($signed(spin_i[8*p +: 8]));
                m_acc[p] = (nxt > 127) ? 127 : (nxt < -128) ? -128 : nxt;
                if (ce_i) begin
                    for (int b = 0; b < 2; b++)
                        m_held[p][b] = (autofire_i[2*p+b] && m_stab[p][4+b]) ? m_held[p][b] + 1 : 0;
                    if (joy_i[32*p +: 20] != m_cand[p]) begin
                        m_cand[p] = joy_i[32*p +: 20];
                        m_age[p] = 1;
                    end else begin
                        m_age[p]++;
                    end
                    if (m_age[p] >= DB + 1) m_stab[p] = m_cand[p];
                end
            end
        end
    endtask

    task automatic cycle(input logic ce);
        logic [1:0] q;
        ce_i = ce;
        @(posedge clk_sys);
        model_clock();
        @(negedge clk_sys);
        spin_stb_i = '0;
        check("model", {18'd0, dut_pins(1), dut_pins(0)}, {18'd0, model_pins(1), model_pins(0)});
        q = {ctrl_p7_o[0], ctrl_p9_o[0]};
        if (q != last_q) quad_moves++;
        last_q = q;
        if (ctrl_p6_o[0] != last_p6) p6_moves++;
        last_p6 = ctrl_p6_o[0];
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cycle(1'b1);
            cycle(1'b0);
        end
    endtask

    initial begin
        int moves0;
        reset = 1'b1;
        ce_i = 1'b0;
        joy_i = '1;
        spin_i = '0;
        spin_stb_i = '0;
        autofire_i = '0;
        ctrl_p5_i = 2'b10;
        ctrl_p8_i = 2'b11;

        repeat (3) cycle(1'b1);
        check("reset_port0", {25'd0, dut_pins(0)}, {25'd0, 7'b1111111});
        check("reset_port1", {25'd0, dut_pins(1)}, {25'd0, 7'b1111111});
        reset = 1'b0;
        ticks(4);
        check("debounce_not_yet", {25'd0, dut_pins(0)}, {25'd0, 7'b1111111});
        ticks(1);
        check("all_ones_key0", {25'd0, dut_pins(0)}, {25'd0, 7'b0011011});

        joy_i[31:0] = '0;
        joy_i[11] = 1'b1;
        joy_i[15] = 1'b1;
        ticks(5);
        check("key3_over_key7", {25'd0, dut_pins(0)}, {25'd0, 7'b0110111});
        joy_i[11] = 1'b0;
        ticks(4);
        check("release_not_yet", {25'd0, dut_pins(0)}, {25'd0, 7'b0110111});
        ticks(1);
        check("key7_alone", {25'd0, dut_pins(0)}, {25'd0, 7'b1100111});
        joy_i[8] = 1'b1;
        ticks(3);
        joy_i[8] = 1'b0;
        ticks(6);
        check("glitch_ignored", {25'd0, dut_pins(0)}, {25'd0, 7'b1100111});

        joy_i[31:0] = '0;
        joy_i[9] = 1'b1;
        joy_i[3] = 1'b1;
        joy_i[4] = 1'b1;
        ctrl_p8_i[0] = 1'b0;
        ticks(5);
        check("both_selects", {25'd0, dut_pins(0)}, {25'd0, 7'b0110011});
        ctrl_p5_i[0] = 1'b1;
        #1;
        check("joy_select_only", {25'd0, dut_pins(0)}, {25'd0, 7'b0111011});
        ctrl_p8_i[0] = 1'b1;
        #1;
        check("no_select", {25'd0, dut_pins(0)}, {25'd0, 7'b1111111});

        spin_i[7:0] = 8'd3;
        spin_stb_i[0] = 1'b1;
        cycle(1'b0);
        ticks(4);
        check("spin_step1", {30'd0, ctrl_p7_o[0], ctrl_p9_o[0]}, 32'b10);
        ticks(4);
        check("spin_step2", {30'd0, ctrl_p7_o[0], ctrl_p9_o[0]}, 32'b00);
        ticks(4);
        check("spin_step3", {30'd0, ctrl_p7_o[0], ctrl_p9_o[0]}, 32'b01);
        ticks(8);
        check("spin_hold", {30'd0, ctrl_p7_o[0], ctrl_p9_o[0]}, 32'b01);
        spin_i[7:0] = 8'hFE;
        spin_stb_i[0] = 1'b1;
        cycle(1'b0);
        ticks(4);
        check("spin_rev1", {30'd0, ctrl_p7_o[0], ctrl_p9_o[0]}, 32'b00);
        ticks(8);
        check("spin_rev_net", {30'd0, ctrl_p7_o[0], ctrl_p9_o[0]}, 32'b10);

        spin_i[7:0] = 8'd100;
        spin_stb_i[0] = 1'b1;
        cycle(1'b0);
        spin_stb_i[0] = 1'b1;
        cycle(1'b0);
        moves0 = quad_moves;
        ticks(127 * SD + 16);
        check("sat_step_count", quad_moves - moves0, 127);
        check("sat_final_state", {30'd0, ctrl_p7_o[0], ctrl_p9_o[0]}, 32'b11);

        spin_i[7:0] = 8'd50;
        spin_stb_i[0] = 1'b1;
        cycle(1'b0);
        ticks(10);
        reset = 1'b1;
        cycle(1'b0);
        check("reset_mid_spin", {30'd0, ctrl_p7_o[0], ctrl_p9_o[0]}, 32'b11);
        reset = 1'b0;
        moves0 = quad_moves;
        ticks(40);
        check("no_steps_after_reset", quad_moves - moves0, 0);

        joy_i[31:0] = '0;
        ticks(5);
        joy_i[4] = 1'b1;
        autofire_i[0] = 1'b1;
        ctrl_p8_i[0] = 1'b0;
        ctrl_p5_i[0] = 1'b1;
        ticks(5);
        check("fire1_pressed", {31'd0, ctrl_p6_o[0]}, 32'd0);
        moves0 = p6_moves;
        ticks(40);
`ifdef CTRL_AUTOFIRE_EN
        check("autofire_toggles", p6_moves - moves0, 5);
`else
        check("autofire_ignored", p6_moves - moves0, 0);
`endif

        repeat (1500) begin
            if ($urandom_range(31) == 0) joy_i[31:0] = $urandom;
            if ($urandom_range(31) == 0) joy_i[63:32] = $urandom;
            ctrl_p5_i = 2'($urandom);
            ctrl_p8_i = 2'($urandom);
            if ($urandom_range(7) == 0) begin
                spin_i = 16'($urandom);
                spin_stb_i = 2'($urandom);
            end
            if ($urandom_range(63) == 0) autofire_i = 4'($urandom);
            reset = ($urandom_range(499) == 0);
            cycle(1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
